// File: rtl/sr_stim_pkg.sv
// sr_stim_pkg: shared state encoding and index-width helper for sr_stim_checker
package sr_stim_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, CHECK, ILLEGAL, DONE} state_t;
  function automatic int SR_STIM_IDX_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/sr_err_counter.sv
// sr_err_counter: saturating mismatch counter with synchronous clear and increment enable
module sr_err_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/sr_stim_checker.sv
// sr_stim_checker: serialises a pattern onto SR s/r and checks q/qb one cycle later
// Optional s=r=1 hold phase after CHECK is enabled by defining SR_STIM_ILLEGAL_PHASE_EN.
module sr_stim_checker
  import sr_stim_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q,
  input  logic             qb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int IW = SR_STIM_IDX_W(WIDTH);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic s_n, r_n, last, clr, inc;
  if (WIDTH < 2 || HOLD_CYCLES < 1) begin : g_cfg_check
    $fatal(1, "sr_stim_checker: WIDTH must be >= 2 and HOLD_CYCLES >= 1");
  end
`ifdef SR_STIM_ILLEGAL_PHASE_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold, hold_n;
  always_ff @(posedge clk) hold <= rst ? '0 : hold_n;
`endif
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sh_n    = sh;
    s_n     = 1'b0;
    r_n     = 1'b0;
`ifdef SR_STIM_ILLEGAL_PHASE_EN
    hold_n  = hold;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = DRIVE;
        idx_n   = '0;
        sh_n    = pattern >> 1;
        s_n     = pattern[0];
        r_n     = ~pattern[0];
      end
      DRIVE: if (idx == IW'(WIDTH - 1)) state_n = CHECK;
      else begin
        idx_n = idx + IW'(1);
        sh_n  = sh >> 1;
        s_n   = sh[0];
        r_n   = ~sh[0];
      end
`ifdef SR_STIM_ILLEGAL_PHASE_EN
      CHECK: begin
        state_n = ILLEGAL;
        hold_n  = '0;
        s_n     = 1'b1;
        r_n     = 1'b1;
      end
      ILLEGAL: if (hold == HW'(HOLD_CYCLES - 1)) state_n = DONE;
      else begin
        hold_n = hold + HW'(1);
        s_n    = 1'b1;
        r_n    = 1'b1;
      end
`else
      CHECK: state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // last holds the bit driven in the previous cycle, which q/qb should now reflect
  assign inc = ((state == DRIVE && idx != '0) || state == CHECK) && (q != last || qb == last);
  assign clr = rst || (state == IDLE && start);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      sh    <= '0;
      last  <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sh    <= sh_n;
      last  <= s;
      s     <= s_n;
      r     <= r_n;
      busy  <= state_n inside {DRIVE, CHECK, ILLEGAL};
      done  <= state_n == DONE;
    end
  sr_err_counter #(.CNT_W(CNT_W)) u_cnt (.clk(clk), .clr(clr), .inc(inc), .cnt(err_cnt));
endmodule

// File: tb/tb_sr_stim_checker.sv
// tb_sr_stim_checker: scoreboard bench with an SR flip-flop model and fault injection
module tb_sr_stim_checker;
  localparam int W = 8;
`ifdef SR_STIM_ILLEGAL_PHASE_EN
  localparam int H = 8;
`else
  localparam int H = 0;
`endif
  localparam int DONE_CYC = W + 2 + H;
  logic clk = 0, rst = 1, start = 0, start2 = 0, stuck = 0, qi = 0;
  logic [W-1:0] pattern = '0;
  logic q, qb, s, r, busy, done, s2, r2, busy2, done2;
  logic [3:0] err_cnt;
  logic [2:0] err2;
  int checks = 0, errors = 0;
  int q1[$], q2[$];
  always #5 clk = ~clk;
  always @(posedge clk)
    if (s && !r) qi <= 1'b1;
    else if (r && !s) qi <= 1'b0;
  assign q  = stuck ? 1'b0 : qi;
  assign qb = stuck ? 1'b1 : ~qi;
  sr_stim_checker #(.WIDTH(W), .CNT_W(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q(q), .qb(qb),
    .s(s), .r(r), .busy(busy), .done(done), .err_cnt(err_cnt));
  sr_stim_checker #(.WIDTH(W), .CNT_W(3), .HOLD_CYCLES(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern), .q(1'b0), .qb(1'b1),
    .s(s2), .r(r2), .busy(busy2), .done(done2), .err_cnt(err2));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=done expected=no_done", name);
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      if (q1.size() == 0) unexpected("done_unexpected");
      else chk("err_cnt_at_done", err_cnt, q1.pop_front());
    end
  always @(negedge clk)
    if (!rst && done2) begin
      if (q2.size() == 0) unexpected("done2_unexpected");
      else chk("sat_err_cnt_at_done", err2, q2.pop_front());
    end
  task automatic run(input logic [W-1:0] p, input logic st, input int exp);
    stuck = st;
    pattern = p;
    q1.push_back(exp);
    start = 1;
    tick();
    start = 0;
    tick(DONE_CYC + 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] p;
    tick(2);
    rst = 0;
    chk("reset_s", s, 0);
    chk("reset_r", r, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err_cnt", err_cnt, 0);
    p = 8'b00110101;
    stuck = 0;
    pattern = p;
    q1.push_back(0);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("drive_s_%0d", i), s, p[i]);
      chk($sformatf("drive_r_%0d", i), r, !p[i]);
      chk($sformatf("drive_busy_%0d", i), busy, 1);
      tick();
    end
    chk("check_s", s, 0);
    chk("check_r", r, 0);
    chk("check_busy", busy, 1);
    tick();
`ifdef SR_STIM_ILLEGAL_PHASE_EN
    for (int i = 0; i < H; i++) begin
      chk($sformatf("illegal_s_%0d", i), s, 1);
      chk($sformatf("illegal_r_%0d", i), r, 1);
      chk($sformatf("illegal_busy_%0d", i), busy, 1);
      tick();
    end
`endif
    chk("done_cycle", done, 1);
    chk("done_busy", busy, 0);
    chk("done_s", s, 0);
    tick();
    chk("done_pulse_width", done, 0);
    chk("err_cnt_hold", err_cnt, 0);
    tick();
    run(8'b00110101, 1, 4);
    chk("err_cnt_held_after_done", err_cnt, 4);
    run(8'h81, 1, 2);
    run(8'h5A, 0, 0);
    stuck = 1;
    pattern = 8'b00110101;
    q1.push_back(4);
    start = 1;
    tick();
    start = 0;
    tick(2);
    start = 1;
    pattern = 8'hFF;
    tick();
    start = 0;
    tick(DONE_CYC - 4);
    chk("ignored_done_cycle", done, 1);
    start = 1;
    tick();
    start = 0;
    chk("ignored_start_in_done_busy", busy, 0);
    chk("ignored_start_in_done_done", done, 0);
    tick(W + 4);
    chk("no_restart_busy", busy, 0);
    chk("no_restart_err_cnt", err_cnt, 4);
    pattern = 8'b00110101;
    start = 1;
    tick();
    start = 0;
    tick(2);
    chk("midrun_err_cnt", err_cnt, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_s", s, 0);
    chk("midrst_r", r, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    tick(DONE_CYC);
    run(8'b00110101, 1, 4);
    pattern = 8'hFF;
    q2.push_back(7);
    start2 = 1;
    tick();
    start2 = 0;
    tick(DONE_CYC + 1);
    chk("sat_err_cnt_final", err2, 7);
    chk("pending_expectations", q1.size() + q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
